// File: rtl/led_mode_if.sv
// Pin-side bundle between the lab top level and the LED mode controller.
interface led_mode_if;
  logic [3:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;

  modport master (output key, sw, input led, mode, paused);
  modport slave  (input key, sw, output led, mode, paused);
endinterface

// File: rtl/led_mode_ctrl.sv
// LED bank controller: key/sw conditioning, key-press commands and four
// display modes (pass-through, running light, blink, binary counter).

module led_mode_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic stable
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == DW'(DEB_CYCLES - 1)) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end
endmodule

module led_mode_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int TICK_CYCLES = 5000000
) (
  input logic       clk,
  input logic       rst,
  led_mode_if.slave bus
);
  localparam int NUM_KEYS = 4;
  localparam int TW       = $clog2(4 * TICK_CYCLES);

  typedef enum logic [1:0] {PASS, SHIFT, BLINK, COUNT} mode_t;

  logic [3:0]    key_s1, key_sync, sw_s1, sw_sync;
  logic [3:0]    stable, stable_d, press;
  mode_t         mode_q;
  logic          paused_q, phase;
  logic [1:0]    speed;
  logic [7:0]    pattern, cnt, led_q;
  logic [TW-1:0] tick_cnt, period_m1;
  logic          tick, init;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1   <= '0;
      key_sync <= '0;
      sw_s1    <= '0;
      sw_sync  <= '0;
    end else begin
      key_s1   <= bus.key;
      key_sync <= key_s1;
      sw_s1    <= bus.sw;
      sw_sync  <= sw_s1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    led_mode_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .sync   (key_sync[i]),
      .stable (stable[i])
    );
  end

  assign press = stable & ~stable_d;
  assign init  = press[0] | press[3];

  // >= rather than == so a speed drop below the running count still wraps
  assign period_m1 = TW'(TICK_CYCLES) * (TW'(speed) + TW'(1)) - TW'(1);
  assign tick      = !paused_q && (tick_cnt >= period_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      mode_q   <= PASS;
      paused_q <= 1'b0;
      speed    <= '0;
      pattern  <= 8'h01;
      cnt      <= '0;
      phase    <= 1'b0;
      tick_cnt <= '0;
      led_q    <= '0;
    end else begin
      stable_d <= stable;
      if (press[0]) mode_q   <= mode_t'(mode_q + 2'd1);
      if (press[1]) paused_q <= ~paused_q;
      if (press[2]) speed    <= speed + 2'd1;

      // clear and mode entry win over a coincident tick
      if (init) begin
        pattern  <= 8'h01;
        cnt      <= '0;
        phase    <= 1'b0;
        tick_cnt <= '0;
      end else begin
        if (!paused_q) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) begin
          case (mode_q)
            SHIFT:   pattern <= sw_sync[0] ? {pattern[0], pattern[7:1]}
                                           : {pattern[6:0], pattern[7]};
            BLINK:   phase   <= ~phase;
            COUNT:   cnt     <= cnt + 8'd1;
            default: ;
          endcase
        end
      end

      case (mode_q)
        PASS:    led_q <= {stable, sw_sync};
        SHIFT:   led_q <= pattern;
        BLINK:   led_q <= phase ? {sw_sync, sw_sync} : 8'h00;
        default: led_q <= cnt;
      endcase
    end
  end

  assign bus.led    = led_q;
  assign bus.mode   = mode_q;
  assign bus.paused = paused_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboarded bench for led_mode_ctrl with short debounce/tick periods.
module tb_led_mode_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  led_mode_if bus();

  led_mode_ctrl #(.DEB_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Key event is applied on the 7th rising edge after the key goes high.
  task automatic press(input logic [3:0] m);
    repeat (8) @(negedge clk);
    bus.key = m;
    repeat (7) @(negedge clk);
    bus.key = 4'b0000;
  endtask

  task automatic test_reset;
    bus.key = 4'b0000;
    bus.sw  = 4'b0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", bus.led); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b expected 0", bus.paused); end
    rst = 1'b0;
  endtask

  task automatic test_pass;
    bit found = 0;
    bus.sw = 4'b1010;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus.led === 8'h0A) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL pass_sw: got %h expected 0a within 8 cycles", bus.led); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL pass_mode: got %0d expected 0", bus.mode); end
    bus.key = 4'b1000;
    repeat (6) @(negedge clk);
    checks++; if (bus.led !== 8'h0A) begin errors++; $display("FAIL pass_lat_early: got %h expected 0a", bus.led); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h8A) begin errors++; $display("FAIL pass_lat_key: got %h expected 8a", bus.led); end
    bus.key = 4'b0000;
    repeat (10) @(negedge clk);
    checks++; if (bus.led !== 8'h0A) begin errors++; $display("FAIL pass_release: got %h expected 0a", bus.led); end
  endtask

  task automatic test_debounce;
    for (int g = 0; g < 2; g++) begin
      bus.key = 4'b0001; repeat (2) @(negedge clk);
      bus.key = 4'b0000; repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL bounce_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.led !== 8'h0A) begin errors++; $display("FAIL bounce_led: got %h expected 0a", bus.led); end
    bus.key = 4'b0001;
    repeat (7) @(negedge clk);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL press_mode: got %0d expected 1", bus.mode); end
    checks++; if (bus.led !== 8'h1A) begin errors++; $display("FAIL press_led_lag: got %h expected 1a", bus.led); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h01) begin errors++; $display("FAIL shift_entry_led: got %h expected 01", bus.led); end
    repeat (2) @(negedge clk);
    bus.key = 4'b0000;
    repeat (12) @(negedge clk);
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL held_one_event: got %0d expected 1", bus.mode); end
  endtask

  task automatic test_shift;
    bus.sw = 4'b1010;
    exp = 8'h01;
    exp_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      exp = {exp[6:0], exp[7]};
      exp_q.push_back(exp);
    end
    press(4'b1000);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (bus.led !== exp) begin errors++; $display("FAIL shift_clear: got %h expected %h", bus.led, exp); end
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus.led !== exp) begin errors++; $display("FAIL shift_left[%0d]: got %h expected %h", i, bus.led, exp); end
    end
    bus.sw = 4'b1011;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h40);
    for (int i = 0; i < 2; i++) begin
      repeat (8) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus.led !== exp) begin errors++; $display("FAIL shift_right[%0d]: got %h expected %h", i, bus.led, exp); end
    end
  endtask

  task automatic test_count;
    press(4'b0001);
    press(4'b0001);
    press(4'b0100);
    press(4'b0100);
    press(4'b1000);
    checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL count_mode: got %0d expected 3", bus.mode); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL count_start: got %h expected 00", bus.led); end
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 256; i++) begin
      repeat (24) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus.led !== exp) begin errors++; $display("FAIL count[%0d]: got %h expected %h", i, bus.led, exp); end
    end
  endtask

  task automatic test_pause_clear;
    repeat (24 * 5) @(negedge clk);
    checks++; if (bus.led !== 8'h05) begin errors++; $display("FAIL count_5: got %h expected 05", bus.led); end
    press(4'b0010);
    checks++; if (bus.paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %b expected 1", bus.paused); end
    repeat (100) @(negedge clk);
    checks++; if (bus.led !== 8'h05) begin errors++; $display("FAIL pause_hold: got %h expected 05", bus.led); end
    press(4'b0010);
    checks++; if (bus.paused !== 1'b0) begin errors++; $display("FAIL pause_off: got %b expected 0", bus.paused); end
    repeat (8) @(negedge clk);
    checks++; if (bus.led !== 8'h05) begin errors++; $display("FAIL resume_hold: got %h expected 05", bus.led); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h06) begin errors++; $display("FAIL resume_next: got %h expected 06", bus.led); end
    press(4'b1000);
    checks++; if (bus.led !== 8'h06) begin errors++; $display("FAIL clear_lag: got %h expected 06", bus.led); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL clear_led: got %h expected 00", bus.led); end
  endtask

  task automatic test_reset_mid;
    repeat (24 * 55) @(negedge clk);
    checks++; if (bus.led !== 8'h37) begin errors++; $display("FAIL count_37: got %h expected 37", bus.led); end
    press(4'b0010);
    checks++; if (bus.paused !== 1'b1 || bus.led !== 8'h37) begin
      errors++; $display("FAIL pre_reset: got paused=%b led=%h expected paused=1 led=37", bus.paused, bus.led);
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL async_led: got %h expected 00", bus.led); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.paused !== 1'b0) begin errors++; $display("FAIL async_paused: got %b expected 0", bus.paused); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_blink;
    bus.sw = 4'b0110;
    press(4'b0001);
    press(4'b0001);
    checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL blink_mode: got %0d expected 2", bus.mode); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL blink_entry: got %h expected 00", bus.led); end
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h66);
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus.led !== exp) begin errors++; $display("FAIL blink[%0d]: got %h expected %h", i, bus.led, exp); end
    end
  endtask

  task automatic test_dual_keys;
    press(4'b0110);
    checks++; if (bus.paused !== 1'b1) begin errors++; $display("FAIL dual_paused: got %b expected 1", bus.paused); end
    press(4'b1000);
    @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL dual_clear: got %h expected 00", bus.led); end
    press(4'b0010);
    repeat (16) @(negedge clk);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL dual_speed_early: got %h expected 00", bus.led); end
    @(negedge clk);
    checks++; if (bus.led !== 8'h66) begin errors++; $display("FAIL dual_speed_tick: got %h expected 66", bus.led); end
  endtask

  task automatic test_mode_wrap;
    press(4'b0001);
    checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", bus.mode); end
    press(4'b0001);
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL wrap_pass: got %0d expected 0", bus.mode); end
    repeat (12) @(negedge clk);
    checks++; if (bus.led !== 8'h06) begin errors++; $display("FAIL wrap_pass_led: got %h expected 06", bus.led); end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_debounce;
    test_shift;
    test_count;
    test_pause_clear;
    test_reset_mid;
    test_blink;
    test_dual_keys;
    test_mode_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Board-level controller that owns the 8-bit LED bank and decides what drives it. It synchronizes and debounces the 4 keys, turns key presses into one-cycle command events, and sequences the LEDs through four display modes. The modes are a pass-through of {key, sw}, a running light, a blink, and a binary counter. It sits between the raw key/sw pins and the LED pins in the lab top level.

Parameters:
DEB_CYCLES, 1000000, consecutive cycles a synchronized key level must differ from the stable level before the stable level updates (20 ms at 50 MHz)
TICK_CYCLES, 5000000, base animation period in clk cycles (0.1 s at 50 MHz)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
key  input  4  push buttons, 1 = pressed
sw   input  4  slide switches
led  output 8  LED drive, registered
mode output 2  current mode: 0 PASS, 1 SHIFT, 2 BLINK, 3 COUNT
paused output 1  1 = animation frozen

Behaviour:
- Reset, asynchronous, active-high; values while rst=1:
  - led=0, mode=PASS, paused=0, speed=0
  - stable keys=0, sync flops=0
  - pattern=8'h01, cnt=0, phase=0, all counters 0
- Input conditioning:
  - key and sw each pass through a 2-flop synchronizer.
  - Per key bit, debounce counter:
    - If sync bit equals stable bit, counter is cleared.
    - Otherwise counter increments; at DEB_CYCLES-1 the stable bit takes the sync value and the counter clears.
  - Press event for bit i = stable[i] & ~stable_d[i], one cycle wide. Releases generate no event.
- Commands, applied on the edge where the event is high:
  - key[0]: mode advances PASS→SHIFT→BLINK→COUNT→PASS.
  - key[1]: toggles paused.
  - key[2]: speed = speed+1 mod 4.
  - key[3]: clear, sets pattern=8'h01, cnt=0, phase=0, tick counter=0. Mode, speed and paused are unchanged.
- Mode entry (any mode change) performs the same initialization as clear.
- Tick generator:
  - Period P = TICK_CYCLES*(speed+1).
  - Counter runs 0..P-1; tick pulses one cycle when the counter equals P-1, then the counter wraps to 0.
  - While paused, the counter holds and no tick is generated.
  - A speed change does not clear the counter. If the counter is already ≥ new P-1, tick fires on the next cycle and the counter wraps.
- Per-mode update on tick:
  - SHIFT: pattern rotates left by 1 if sw_sync[0]=0, right by 1 if sw_sync[0]=1. 8'h80 wraps to 8'h01 (left); 8'h01 wraps to 8'h80 (right).
  - BLINK: phase toggles.
  - COUNT: cnt increments, 8'hFF wraps to 8'h00.
  - PASS: no state change.
- LED output register, updated every cycle from current state:
  - PASS: {stable, sw_sync}, stable key in the high nibble.
  - SHIFT: pattern.
  - BLINK: phase ? {sw_sync, sw_sync} : 8'h00.
  - COUNT: cnt.
- Latency:
  - Pin change → led in PASS: 2 sync + DEB_CYCLES + 1 cycles.
  - Press event → new mode visible on the `mode` port 1 cycle later; led reflects it the following cycle.
- Simultaneous events, all applied in the same cycle:
  - Clear or mode entry overrides a coincident tick update.
  - key[1] and key[2] together: both take effect.
- Bounce: a level held fewer than DEB_CYCLES cycles never changes stable and produces no event.
- Reset mid-animation immediately forces all reset values; no event is pending after release.
- Held key: exactly one event per press.

Test Plan:
- Override DEB_CYCLES=4, TICK_CYCLES=8, reset, then key=4'b0000, sw=4'b1010 → led=8'h0A within 8 cycles, mode=0.
- key[0] high-low-high glitches of 2 cycles each, then stable high 10 cycles → exactly one event; mode goes 0→1; led=8'h01.
- SHIFT mode, sw[0]=0, speed 0 → led 01,02,04,…,80,01 every 8 cycles. Set sw[0]=1 → the next tick gives 8'h80 from 8'h01.
- Press key[0] twice more (COUNT), then key[2] twice (speed=2) → cnt increments every 24 cycles. Run 256 ticks → led wraps 8'hFF→8'h00.
- Press key[1] in COUNT at cnt=5 → led holds 8'h05 for 100 cycles with paused=1. Press again → counting resumes from 5. Press key[3] → led=8'h00 one cycle after the clear is applied.
- Assert rst mid-COUNT with cnt=8'h37 → led=0, mode=0, paused=0 asynchronously. After release, BLINK entry with sw=4'b0110 → led alternates 8'h00/8'h66 every 8 cycles.
